// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory boot loader.
package mips_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte assembler: the first byte of a word lands in [31:24].
// word_valid fires combinationally alongside the byte that completes a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = byte_en && (cnt_q == 2'(WORD_BYTES - 1));
    word_out   = {shift_q, byte_in};
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_en) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length-prefixed byte stream in,
// word writes out, core held in reset until the whole image is written.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic            reload,
  output logic            imem_we,
  output logic [31:0]     imem_addr,
  output logic [31:0]     imem_wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

  loader_state_t     state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;

  logic              accept;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;
  logic              pk_clr;
  logic              pk_en;
  logic              word_valid;
  logic [31:0]       word_out;

  assign rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {len_hi_q, rx_data};
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};
  assign pk_clr    = (state_q == LEN_LO) && accept;
  assign pk_en     = (state_q == DATA) && accept;

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_d = DONE;
          end else if ({1'b0, len_full} > MAX_WORDS_L) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            len_d      = len_full[ADDR_W:0];
            word_idx_d = '0;
            words_d    = '0;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          we_d       = 1'b1;
          addr_d     = {{(30 - ADDR_W){1'b0}}, word_idx_q, 2'b00};
          wdata_d    = word_out;
          word_idx_d = word_idx_q + 1'b1;
          words_d    = words_inc;
          if (words_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        // Hold drops one cycle after DONE so the final write lands first.
        hold_d = 1'b0;
        if (reload) begin
          state_d = LEN_HI;
          hold_d  = 1'b1;
          words_d = '0;
        end
      end
      ERR: begin
        if (reload) begin
          state_d = LEN_HI;
          hold_d  = 1'b1;
          words_d = '0;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LEN_HI;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: fixed-timing byte streams with
// hand-computed expected writes, flags and hold timing.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int base;

  imem_loader #(.ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts every cycle with the write strobe high, to catch extra or missing writes.
  always @(negedge clock) if (imem_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'h77;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clock); #1;
    reload = 1'b0;
  endtask

  // Stream 00 02 20 08 00 05 01 09 50 20 with checks on both writes and the hold release.
  task automatic run_stream1(input string pfx);
    int b0;
    b0 = we_cnt;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    chk({pfx, "_w0_we"},   {31'd0, imem_we},    32'd1);
    chk({pfx, "_w0_addr"}, imem_addr,           32'h0000_0000);
    chk({pfx, "_w0_data"}, imem_wdata,          32'h2008_0005);
    chk({pfx, "_w0_done"}, {31'd0, done},       32'd0);
    send_byte(8'h01);
    chk({pfx, "_we_1cyc"}, {31'd0, imem_we},    32'd0);
    send_byte(8'h09); send_byte(8'h50); send_byte(8'h20);
    chk({pfx, "_w1_we"},   {31'd0, imem_we},    32'd1);
    chk({pfx, "_w1_addr"}, imem_addr,           32'h0000_0004);
    chk({pfx, "_w1_data"}, imem_wdata,          32'h0109_5020);
    chk({pfx, "_done"},    {31'd0, done},       32'd1);
    chk({pfx, "_words"},   {23'd0, words_loaded}, 32'd2);
    chk({pfx, "_hold_hi"}, {31'd0, cpu_hold},   32'd1);
    idle(1);
    chk({pfx, "_hold_lo"}, {31'd0, cpu_hold},   32'd0);
    chk({pfx, "_rdy_lo"},  {31'd0, rx_ready},   32'd0);
    chk({pfx, "_we_cnt"},  32'(we_cnt - b0),    32'd2);
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_we",    {31'd0, imem_we},  32'd0);
    chk("rst_addr",  imem_addr,         32'd0);
    chk("rst_wdata", imem_wdata,        32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, error},    32'd0);
    chk("rst_words", {23'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_rdy",   {31'd0, rx_ready}, 32'd1);

    run_stream1("t1");

    // reload in DONE, then a single word AC0A0000
    pulse_reload();
    chk("rl_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rl_done",  {31'd0, done},     32'd0);
    chk("rl_words", {23'd0, words_loaded}, 32'd0);
    chk("rl_rdy",   {31'd0, rx_ready}, 32'd1);
    base = we_cnt;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAC); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h00);
    chk("t6_we",    {31'd0, imem_we},  32'd1);
    chk("t6_addr",  imem_addr,         32'h0000_0000);
    chk("t6_data",  imem_wdata,        32'hAC0A_0000);
    chk("t6_words", {23'd0, words_loaded}, 32'd1);
    chk("t6_done",  {31'd0, done},     32'd1);
    idle(1);
    chk("t6_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t6_wecnt", 32'(we_cnt - base), 32'd1);

    // zero-length image
    pulse_reload();
    base = we_cnt;
    send_byte(8'h00); send_byte(8'h00);
    chk("t2_done",   {31'd0, done},     32'd1);
    chk("t2_hold_h", {31'd0, cpu_hold}, 32'd1);
    chk("t2_rdy",    {31'd0, rx_ready}, 32'd0);
    idle(1);
    chk("t2_hold_l", {31'd0, cpu_hold}, 32'd0);
    idle(3);
    chk("t2_wecnt",  32'(we_cnt - base), 32'd0);
    chk("t2_words",  {23'd0, words_loaded}, 32'd0);

    // oversize length 257 -> ERR, sticky until reload
    pulse_reload();
    send_byte(8'h01); send_byte(8'h01);
    chk("t3_err",    {31'd0, error},    32'd1);
    chk("t3_rdy",    {31'd0, rx_ready}, 32'd0);
    chk("t3_hold",   {31'd0, cpu_hold}, 32'd1);
    chk("t3_done",   {31'd0, done},     32'd0);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rx_valid = 1'b0;
    chk("t3_err_st", {31'd0, error},    32'd1);
    chk("t3_hold_st",{31'd0, cpu_hold}, 32'd1);
    pulse_reload();
    chk("t3_rl_err", {31'd0, error},    32'd0);
    chk("t3_rl_rdy", {31'd0, rx_ready}, 32'd1);
    chk("t3_rl_hold",{31'd0, cpu_hold}, 32'd1);

    // one word with 3-cycle bubbles between bytes
    base = we_cnt;
    send_byte(8'h00); idle(3);
    send_byte(8'h01); idle(3);
    send_byte(8'hDE); idle(3);
    send_byte(8'hAD); idle(3);
    send_byte(8'hBE); idle(3);
    chk("t4_nowe",   {31'd0, imem_we},  32'd0);
    chk("t4_rdy",    {31'd0, rx_ready}, 32'd1);
    send_byte(8'hEF);
    chk("t4_we",     {31'd0, imem_we},  32'd1);
    chk("t4_addr",   imem_addr,         32'h0000_0000);
    chk("t4_data",   imem_wdata,        32'hDEAD_BEEF);
    chk("t4_done",   {31'd0, done},     32'd1);
    idle(2);
    chk("t4_wecnt",  32'(we_cnt - base), 32'd1);
    chk("t4_words",  {23'd0, words_loaded}, 32'd1);

    // full capacity: 256 words, word i = A5 i 5A ~i
    pulse_reload();
    base = we_cnt;
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 255; i++) begin
      send_byte(8'hA5); send_byte(8'(i)); send_byte(8'h5A); send_byte(~8'(i));
      if (i == 1) begin
        chk("t7_w1_addr", imem_addr,  32'h0000_0004);
        chk("t7_w1_data", imem_wdata, 32'hA501_5AFE);
      end
    end
    chk("t7_notdone", {31'd0, done}, 32'd0);
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h5A); send_byte(8'h00);
    chk("t7_we",    {31'd0, imem_we},  32'd1);
    chk("t7_addr",  imem_addr,         32'h0000_03FC);
    chk("t7_data",  imem_wdata,        32'hA5FF_5A00);
    chk("t7_done",  {31'd0, done},     32'd1);
    chk("t7_words", {23'd0, words_loaded}, 32'd256);
    idle(1);
    chk("t7_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t7_wecnt", 32'(we_cnt - base), 32'd256);

    // async reset after 6 bytes, then resend
    pulse_reload();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_we",    {31'd0, imem_we},  32'd0);
    chk("t5_addr",  imem_addr,         32'd0);
    chk("t5_wdata", imem_wdata,        32'd0);
    chk("t5_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t5_done",  {31'd0, done},     32'd0);
    chk("t5_err",   {31'd0, error},    32'd0);
    chk("t5_words", {23'd0, words_loaded}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("t5_rdy",   {31'd0, rx_ready}, 32'd1);
    run_stream1("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
